// File: rtl/elevator_car_if.sv
// Command/status bundle between the elevator controller and the car plant.
// The controller side is the master; the car answers as the slave.
interface elevator_car_if;
    logic [1:0] Dir;
    logic       open_req;
    logic [1:0] Floor;
    logic       moving;
    logic       arrived;
    logic       door_busy;
    logic       door_open;
    logic       fault;

    modport master (
        output Dir, open_req,
        input  Floor, moving, arrived, door_busy, door_open, fault
    );

    modport slave (
        input  Dir, open_req,
        output Floor, moving, arrived, door_busy, door_open, fault
    );
endinterface

// File: rtl/elevator_car.sv
// Car/shaft plant and actuator sequencer for the 4-floor elevator.
// Models travel and door timing in response to controller commands.
module elevator_car #(
    parameter int TRAVEL_CYCLES     = 8,
    parameter int DOOR_TRANS_CYCLES = 2,
    parameter int DOOR_CYCLES       = 6
) (
    input  logic           clk,
    input  logic           rst,
    elevator_car_if.slave  bus
);

    localparam int MAXA = (TRAVEL_CYCLES > DOOR_TRANS_CYCLES) ?
                          TRAVEL_CYCLES : DOOR_TRANS_CYCLES;
    localparam int MAXC = (MAXA > DOOR_CYCLES) ? MAXA : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TRV_LAST = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] TRN_LAST = CW'(DOOR_TRANS_CYCLES - 1);
    localparam logic [CW-1:0] DWL_LAST = CW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVING,
        S_OPENING,
        S_OPEN,
        S_CLOSING
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    floor_q, floor_d;
    logic          up_q, up_d;
    logic          arrived_q, arrived_d;
    logic          fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            floor_q   <= 2'b00;
            up_q      <= 1'b0;
            arrived_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            floor_q   <= floor_d;
            up_q      <= up_d;
            arrived_q <= arrived_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        floor_d   = floor_q;
        up_d      = up_q;
        arrived_d = 1'b0;
        fault_d   = fault_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // door request outranks any motion command
                if (bus.open_req) begin
                    state_d = S_OPENING;
                end else if (bus.Dir == 2'b10 && floor_q != 2'b11) begin
                    state_d = S_MOVING;
                    up_d    = 1'b1;
                end else if (bus.Dir == 2'b01 && floor_q != 2'b00) begin
                    state_d = S_MOVING;
                    up_d    = 1'b0;
                end else if (bus.Dir != 2'b00) begin
                    fault_d = 1'b1;
                end
            end
            S_MOVING: begin
                if (cnt_q == TRV_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    floor_d   = up_q ? floor_q + 2'd1 : floor_q - 2'd1;
                    arrived_d = 1'b1;
                end
            end
            S_OPENING: begin
                if (cnt_q == TRN_LAST) begin
                    state_d = S_OPEN;
                    cnt_d   = '0;
                end
            end
            S_OPEN: begin
                if (bus.open_req) begin
                    cnt_d = '0;
                end else if (cnt_q == DWL_LAST) begin
                    state_d = S_CLOSING;
                    cnt_d   = '0;
                end
            end
            S_CLOSING: begin
                // a request while closing reverses the door
                if (bus.open_req) begin
                    state_d = S_OPENING;
                    cnt_d   = '0;
                end else if (cnt_q == TRN_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.Floor     = floor_q;
    assign bus.arrived   = arrived_q;
    assign bus.fault     = fault_q;
    assign bus.moving    = (state_q == S_MOVING);
    assign bus.door_open = (state_q == S_OPEN);
    assign bus.door_busy = (state_q == S_OPENING) ||
                           (state_q == S_OPEN) ||
                           (state_q == S_CLOSING);

endmodule
